ftoi_pipe: RTL
==============

Name: ftoi_pipe

Overview:
- Pipelined float-to-integer converter (IEEE-754 single to signed 32-bit) for the FPU conversion path.
- It is the counterpart of itof and feeds it in the fcvt round-trip path.
- Two register stages with valid/ready handshakes on both sides.
- Sits between the FPU issue logic and the integer writeback mux.

Parameters:
ROUND_MODE, 1, 1 = round to nearest with ties away from zero; 0 = truncate toward zero

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  converter can accept operand this cycle
x  input  32  IEEE-754 single operand {s, e[7:0], m[22:0]}
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
y  output  32  signed 32-bit result
ovf  output  1  result saturated (out of range or NaN)

Behaviour:
- Reset (rstn=0 at a rising edge): both stage valid bits are cleared. out_valid=0, y=0, ovf=0. Any in-flight operands are discarded.
- Handshake: a transfer occurs when valid&ready are both 1 on a clock edge.
  - in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
  - s2 loads from s1 when s1_valid & (!s2_valid | out_ready).
  - s2 clears when out_ready & !(s1_valid) on a draining edge.
  - Simultaneous accept at both ends in one cycle is legal. Throughput is 1 result/cycle.
- Latency: exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
- Order: results leave in acceptance order. No reordering, no drop.
- out_valid, y and ovf hold stable while out_valid=1 and out_ready=0.
- Stage 1 (unpack/shift):
  - Form mantissa {1, m} (24 bits).
  - Unbiased exponent k = e - 127.
  - k in [0,30]: mag = {1,m} shifted so the integer part is bits [30:0], keeping a guard bit and a sticky bit.
  - k < -1: magnitude 0, guard 0.
  - k = -1: integer 0, guard 1.
  - Register sign, integer magnitude (31 b), guard, and a class code {ZERO, NORMAL, SAT_POS, SAT_NEG}.
- Classification:
  - e=0 (zero or denormal) -> ZERO.
  - e=255 with m!=0 (NaN) -> SAT_POS.
  - e=255 with m=0 (inf) -> SAT by sign.
  - k >= 31 -> SAT by sign, except x=0xCF000000 (exactly -2^31), which is NORMAL and yields 0x80000000 with ovf=0.
- Stage 2 (round/negate/saturate):
  - ROUND_MODE=1: mag += guard. Ties go away from zero; sticky is ignored for the decision.
  - ROUND_MODE=0: guard is ignored.
  - If a positive rounded magnitude reaches 2^31 -> saturate to 0x7FFFFFFF with ovf=1.
  - Negative: y = -mag (two's complement). Range reaching 2^31 gives 0x80000000 with ovf=0.
  - SAT_POS -> 0x7FFFFFFF, ovf=1. SAT_NEG -> 0x80000000, ovf=1. ZERO -> 0, ovf=0.
  - -0.0 -> 0. A result of -0 after rounding is emitted as 0x00000000.
- Arithmetic is 32-bit unsigned internal with a carry-out bit for overflow detection. There are no X-producing paths: every case branch has a default.

Test Plan:
- Rounding: 0x3FC00000 (1.5) -> 0x00000002; 0x40200000 (2.5) -> 0x00000003; 0xC0200000 (-2.5) -> 0xFFFFFFFD; all ovf=0, each out_valid exactly 2 cycles after acceptance.
- Half boundary: 0x3EFFFFFF (~0.49999997) -> 0; 0x3F000000 (0.5) -> 1; 0x80000000 (-0.0) -> 0; 0x00000001 (denormal) -> 0.
- Saturation:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, ovf=1.
  - 0xCF000000 (-2^31) -> 0x80000000, ovf=0.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, ovf=1.
  - 0xFF800000 (-inf) -> 0x80000000, ovf=1.
  - 0x4EFFFFFF (2147483520.0) -> 0x7FFFFF80, ovf=0.
- Backpressure:
  - Drive 4 back-to-back operands 1.0, 2.0, 3.0, 4.0 with out_ready=0.
  - in_ready must fall after 2 accepts.
  - Raising out_ready must yield 1, 2, 3, 4 in order, one per cycle, with y stable while stalled.
- Reset mid-operation: with 2 results in flight, assert rstn=0 for one edge. out_valid=0, y=0, ovf=0 next cycle; in_ready=1; no stale result ever appears.
- ROUND_MODE=0 build: 0x402CCCCD (2.7) -> 2; 0xC02CCCCD (-2.7) -> 0xFFFFFFFE; 0x3F7FFFFF -> 0.

Source files
------------

// File: rtl/ftoi_pipe_if.sv
// ftoi_pipe_if: operand/result handshake bundle for the float-to-int converter.
//   in_valid/in_ready/x           : operand side (issue logic -> converter)
//   out_valid/out_ready/y/ovf     : result side (converter -> writeback mux)
// master drives operands and consumes results; slave is the converter itself.
interface ftoi_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage pipelined IEEE-754 single -> signed 32-bit converter.
//   clk  : clock, all state on the rising edge
//   rstn : synchronous active-low reset, clears both stage valid bits and the outputs
//   bus  : ftoi_pipe_if.slave (operand in, result y/ovf out, valid/ready on both sides)
// Stage 1 unpacks, classifies and aligns the mantissa into an integer magnitude plus
// a guard bit. Stage 2 rounds, negates and saturates, and its registers are the outputs.
// ROUND_MODE: 1 = round to nearest, ties away from zero; 0 = truncate toward zero.
module ftoi_pipe #(
  parameter int unsigned ROUND_MODE = 1
) (
  input logic         clk,
  input logic         rstn,
  ftoi_pipe_if.slave  bus
);

  localparam logic RoundEn = (ROUND_MODE != 0);

  typedef enum logic [1:0] {
    ClsZero,
    ClsNormal,
    ClsSatPos,
    ClsSatNeg
  } cls_e;

  // Stage 1 registers
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [31:0] s1_mag_q;
  logic        s1_guard_q;
  cls_e        s1_cls_q;

  // Stage 2 registers (drive the outputs directly)
  logic        s2_valid_q;
  logic [31:0] s2_y_q;
  logic        s2_ovf_q;

  // Handshake
  logic s1_advance;
  logic in_accept;

  assign s1_advance   = !s2_valid_q | bus.out_ready;
  assign bus.in_ready = !s1_valid_q | s1_advance;
  assign in_accept    = bus.in_valid & bus.in_ready;

  assign bus.out_valid = s2_valid_q;
  assign bus.y         = s2_y_q;
  assign bus.ovf       = s2_ovf_q;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, classify, align
  // ---------------------------------------------------------------------------
  logic        in_sign;
  logic [7:0]  in_expo;
  logic [22:0] in_frac;
  logic        in_is_min_int;
  logic [5:0]  rsh;
  logic [32:0] aligned;
  cls_e        cls_d;
  logic [31:0] mag_d;
  logic        guard_d;

  assign in_sign       = bus.x[31];
  assign in_expo       = bus.x[30:23];
  assign in_frac       = bus.x[22:0];
  assign in_is_min_int = (bus.x == 32'hCF00_0000);

  // The 33-bit aligned word holds the 32-bit integer part in [32:1] and the
  // guard (2^-1) bit in [0]. The leading one sits at bit 32 for k = 31, so the
  // right shift is 31 - k = 158 - e. Bits shifted past the guard are the sticky
  // part, which ties-away rounding never needs.
  always_comb begin
    cls_d   = ClsNormal;
    mag_d   = 32'd0;
    guard_d = 1'b0;
    rsh     = 6'd0;
    aligned = 33'd0;
    if (in_expo == 8'd0) begin
      cls_d = ClsZero;
    end else if (in_expo == 8'hFF) begin
      // NaN saturates positive regardless of sign; infinity follows its sign.
      cls_d = ((in_frac != 23'd0) || !in_sign) ? ClsSatPos : ClsSatNeg;
    end else if ((in_expo >= 8'd158) && !in_is_min_int) begin
      cls_d = in_sign ? ClsSatNeg : ClsSatPos;
    end else if (in_expo >= 8'd126) begin
      // e in [126,157], plus exactly -2^31 at e = 158 which aligns to 0x80000000.
      rsh     = 6'(8'd158 - in_expo);
      aligned = {1'b1, in_frac, 9'd0} >> rsh;
      mag_d   = aligned[32:1];
      guard_d = aligned[0];
    end
    // e < 126 (|x| < 0.5): stays NORMAL with zero magnitude and zero guard.
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round, negate, saturate
  // ---------------------------------------------------------------------------
  logic [32:0] sum;
  logic [31:0] y_d;
  logic        ovf_d;

  // 33-bit sum keeps the carry-out so a rounded magnitude of 2^31 is visible.
  assign sum = {1'b0, s1_mag_q} + {32'd0, RoundEn & s1_guard_q};

  always_comb begin
    y_d   = 32'd0;
    ovf_d = 1'b0;
    case (s1_cls_q)
      ClsZero: begin
        y_d   = 32'd0;
        ovf_d = 1'b0;
      end
      ClsSatPos: begin
        y_d   = 32'h7FFF_FFFF;
        ovf_d = 1'b1;
      end
      ClsSatNeg: begin
        y_d   = 32'h8000_0000;
        ovf_d = 1'b1;
      end
      default: begin
        if (!s1_sign_q) begin
          if (sum[32] | sum[31]) begin
            y_d   = 32'h7FFF_FFFF;
            ovf_d = 1'b1;
          end else begin
            y_d = sum[31:0];
          end
        end else if (sum > 33'h0_8000_0000) begin
          y_d   = 32'h8000_0000;
          ovf_d = 1'b1;
        end else begin
          // Magnitude 2^31 negates to 0x80000000 without overflow; a zero
          // magnitude negates to 0, so -0 never escapes.
          y_d = 32'd0 - sum[31:0];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= 32'd0;
      s1_guard_q <= 1'b0;
      s1_cls_q   <= ClsZero;
      s2_valid_q <= 1'b0;
      s2_y_q     <= 32'd0;
      s2_ovf_q   <= 1'b0;
    end else begin
      if (in_accept) begin
        s1_valid_q <= 1'b1;
        s1_sign_q  <= in_sign;
        s1_mag_q   <= mag_d;
        s1_guard_q <= guard_d;
        s1_cls_q   <= cls_d;
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_advance) begin
        s2_valid_q <= s1_valid_q;
        // Result registers only change on a real load so y/ovf hold while stalled.
        if (s1_valid_q) begin
          s2_y_q   <= y_d;
          s2_ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule
